serial_word_tx: RTL
===================

SERIAL_WORD_TX -- requirements
Module: serial_word_tx

Interface
REQ-001 SHALL have parameter NUM_BITS, default 16, data word width; legal range 2..64.
REQ-002 SHALL have parameter SHIFT_MSB, default 1: 1 = data MSB first, 0 = data LSB first.
REQ-003 SHALL have parameter BIT_PERIOD, default 4, clock cycles per serial bit; legal range 1..1024.
REQ-004 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have n_rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have load_data  input  NUM_BITS  parallel word to transmit.
REQ-007 SHALL have load_valid  input  1  load_data is valid.
REQ-008 SHALL have load_ready  output  1  block can accept a word this cycle.
REQ-009 SHALL have serial_out  output  1  registered serial line; idles high.
REQ-010 SHALL have tx_active  output  1  high while a frame is on the line.
REQ-011 SHALL have tx_done  output  1  one-cycle pulse in the last cycle of a frame's stop bit.

Function
REQ-012 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; PARITY is reachable only per REQ-027.
REQ-013 SHALL drive load_ready = 1 only in IDLE; a transfer occurs on a rising edge with load_valid && load_ready.
REQ-014 SHALL, on a transfer, capture load_data, enter START, and drive serial_out = 0 from the next cycle.
REQ-015 SHALL hold each bit (start, data, parity, stop) on serial_out for exactly BIT_PERIOD cycles, timed by a down-counter reloaded at each bit boundary.
REQ-016 SHALL send NUM_BITS data bits in DATA, order per SHIFT_MSB, tracked by a bit counter of width $clog2(NUM_BITS+1).
REQ-017 SHALL drive serial_out = 1 in STOP and IDLE.
REQ-018 SHALL move STOP -> IDLE after the last stop-bit cycle; load_ready rises the following cycle, so back-to-back frames have one idle cycle of line-high between stop and next start.
REQ-019 SHALL ignore load_valid and load_data whenever load_ready = 0; the in-flight word is never corrupted.
REQ-020 SHALL assert tx_active in START, DATA, PARITY, STOP; deassert in IDLE.
REQ-021 SHALL give frame length (NUM_BITS + 2) * BIT_PERIOD cycles, plus BIT_PERIOD with parity enabled.
REQ-022 SHALL support BIT_PERIOD = 1 with no idle cycles between bits inside a frame.

Reset
REQ-023 SHALL on n_rst = 0 immediately force state IDLE, serial_out = 1, load_ready = 0 while reset is asserted, tx_active = 0, tx_done = 0, shift register all ones, counters zero.
REQ-024 SHALL abort any frame on mid-frame reset; no partial-frame completion or tx_done follows.
REQ-025 SHALL assert load_ready on the first clock edge after n_rst deasserts.

Configuration
REQ-026 SHALL compile the parity feature only when macro SERIAL_WORD_TX_PARITY_EN is defined.
REQ-027 SHALL, with SERIAL_WORD_TX_PARITY_EN, insert PARITY between DATA and STOP carrying even parity (XOR of all captured data bits) for BIT_PERIOD cycles.
REQ-028 SHALL, without SERIAL_WORD_TX_PARITY_EN, go DATA -> STOP directly and contain no parity logic.

Structure
REQ-029 SHALL place the FSM state enum typedef and the idle/start/stop line-level constants in package serial_word_tx_pkg.
REQ-030 SHALL instantiate sub-module flex_pts_sr (parameters NUM_BITS, SHIFT_MSB; ports clk, n_rst, load_enable, shift_enable, parallel_in, serial_out; reset to all ones; fill shifted-in bits with 1).

Verification (NUM_BITS=8, BIT_PERIOD=4 unless stated)
REQ-031 SHALL test SHIFT_MSB=1, load 8'hA5 -> serial_out 0,1,0,1,0,0,1,0,1,1 each 4 cycles, 40 cycles total, tx_done on cycle 40.
REQ-032 SHALL test SHIFT_MSB=0, load 8'h01 -> serial_out 0,1,0,0,0,0,0,0,0,1 each 4 cycles.
REQ-033 SHALL test load_valid held high with 8'h3C then 8'hFF -> second start bit begins exactly 1 cycle after first frame's tx_done; 8'hFF presented during frame 1 not accepted.
REQ-034 SHALL test n_rst pulsed low at cycle 17 of a frame -> serial_out = 1 asynchronously, no tx_done, load_ready = 1 one edge after release.
REQ-035 SHALL test with SERIAL_WORD_TX_PARITY_EN, 8'h07 -> parity bit 1, frame 44 cycles; 8'hA5 -> parity bit 0.
REQ-036 SHALL test BIT_PERIOD=1, 8'h80, SHIFT_MSB=1 -> 0,1,0,0,0,0,0,0,0,1 in 10 consecutive cycles.

Source files
------------

// File: rtl/serial_word_tx_pkg.sv
// Shared types and line levels for the serial word transmitter.
package serial_word_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/serial_word_tx_flex_pts_sr.sv
// Parallel-to-serial shift register; vacated positions fill with the idle line level.
module flex_pts_sr
  import serial_word_tx_pkg::*;
#(
  parameter int NUM_BITS  = 16,
  parameter int SHIFT_MSB = 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load_enable,
  input  logic                shift_enable,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic                serial_out
);

  logic [NUM_BITS-1:0] sr_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr_q <= '1;
    end else if (load_enable) begin
      sr_q <= parallel_in;
    end else if (shift_enable) begin
      if (SHIFT_MSB != 0) begin
        sr_q <= {sr_q[NUM_BITS-2:0], LINE_IDLE};
      end else begin
        sr_q <= {LINE_IDLE, sr_q[NUM_BITS-1:1]};
      end
    end
  end

  assign serial_out = (SHIFT_MSB != 0) ? sr_q[NUM_BITS-1] : sr_q[0];

endmodule

// File: rtl/serial_word_tx.sv
// Framed serial word transmitter: start bit, NUM_BITS data bits, stop bit.
// Define SERIAL_WORD_TX_PARITY_EN to add an even-parity bit between data and stop.
// Handshake: a word transfers on a rising edge where load_valid && load_ready;
// load_ready is high only while idle, so nothing presented mid-frame is taken.
module serial_word_tx
  import serial_word_tx_pkg::*;
#(
  parameter int NUM_BITS   = 16,
  parameter int SHIFT_MSB  = 1,
  parameter int BIT_PERIOD = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NUM_BITS-1:0] load_data,
  input  logic                load_valid,
  output logic                load_ready,
  output logic                serial_out,
  output logic                tx_active,
  output logic                tx_done,
  output tx_state_t           dbg_state
);

  localparam int TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int CW = $clog2(NUM_BITS + 1);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] LAST_BIT     = CW'(NUM_BITS);

  tx_state_t       state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            line_q, line_d;
  logic            armed_q;
  logic            sr_load, sr_shift, sr_bit;
  logic            bit_end;

`ifdef SERIAL_WORD_TX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      parity_q <= 1'b0;
    end else if (sr_load) begin
      parity_q <= ^load_data;
    end
  end
`endif

  flex_pts_sr #(
    .NUM_BITS (NUM_BITS),
    .SHIFT_MSB(SHIFT_MSB)
  ) u_sr (
    .clk         (clk),
    .n_rst       (n_rst),
    .load_enable (sr_load),
    .shift_enable(sr_shift),
    .parallel_in (load_data),
    .serial_out  (sr_bit)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      line_q    <= LINE_IDLE;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      line_q    <= line_d;
      armed_q   <= 1'b1;
    end
  end

  assign bit_end = (timer_q == '0);

  // line_d is the level of the next bit, so serial_out changes exactly on bit boundaries.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    line_d    = line_q;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    case (state_q)
      IDLE: begin
        line_d = LINE_IDLE;
        if (load_valid && load_ready) begin
          state_d = START;
          timer_d = TIMER_RELOAD;
          line_d  = LINE_START;
          sr_load = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          timer_d   = TIMER_RELOAD;
          line_d    = sr_bit;
          sr_shift  = 1'b1;
          bit_cnt_d = CW'(1);
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_d = TIMER_RELOAD;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
            state_d = PARITY;
            line_d  = parity_q;
`else
            state_d = STOP;
            line_d  = LINE_STOP;
`endif
          end else begin
            line_d    = sr_bit;
            sr_shift  = 1'b1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
`ifdef SERIAL_WORD_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          timer_d = TIMER_RELOAD;
          line_d  = LINE_STOP;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          timer_d = '0;
          line_d  = LINE_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        timer_d   = '0;
        bit_cnt_d = '0;
        line_d    = LINE_IDLE;
      end
    endcase
  end

  assign load_ready = (state_q == IDLE) && armed_q;
  assign serial_out = line_q;
  assign tx_active  = (state_q != IDLE);
  assign tx_done    = (state_q == STOP) && bit_end;
  assign dbg_state  = state_q;

endmodule
